train_sequencer: RTL and testbench

//  Epoch/sample sequencer driving the pattern store: issues START, per-sample TR/VL

---
 rtl/train_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_train_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
//
// Epoch/sample sequencer for the pattern store. A run starts on `go` in IDLE
// with a START pulse. Each epoch has TRAIN training samples (TR strobes) and
// then VALID validation samples (VL strobes), followed by one SW
// (store-weights) pulse. The run ends with an END pulse. After each strobe
// the sequencer waits for the architecture's s_done pulse before issuing the
// next sample. A watchdog aborts a stalled wait: it sets err and pulses END.
//
// Every output is a flop, decoded from the next state, so each strobe is
// high for exactly the cycles the FSM spends in the matching state.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   go                  run request, sampled in IDLE only
//   TRAIN/VALID/EPOCH   per-run counts, latched when go is accepted
//   s_done              architecture finished the current sample
//   START/TR/VL/SW/END  one-cycle strobes
//   busy                high from the START cycle through the END cycle
//   err                 sticky watchdog flag, cleared by the next accepted go
//   sample_idx          index of the current sample within its phase
//   epoch_idx           number of completed epochs
// -----------------------------------------------------------------------------
module train_sequencer #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [BITS-1:0] TRAIN,
    input  logic [BITS-1:0] VALID,
    input  logic [BITS-1:0] EPOCH,
    input  logic            s_done,
    output logic            START,
    output logic            TR,
    output logic            VL,
    output logic            SW,
    output logic            END,
    output logic            busy,
    output logic            err,
    output logic [BITS-1:0] sample_idx,
    output logic [BITS-1:0] epoch_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_STRT, S_T_REQ, S_T_WAIT, S_V_REQ, S_V_WAIT, S_STORE, S_FIN
    } state_e;

    // The watchdog counts 0 .. TIMEOUT-1. It fires on the cycle that holds
    // the last count, unless s_done arrives in that same cycle.
    localparam int unsigned    WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit             WD_EN   = (TIMEOUT != 0);

    state_e          state_q, state_d;
    logic [BITS-1:0] train_q, train_d;
    logic [BITS-1:0] valid_q, valid_d;
    logic [BITS-1:0] epoch_q, epoch_d;
    logic [BITS-1:0] sample_q, sample_d;
    logic [BITS-1:0] epoch_cnt_q, epoch_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            start_q, tr_q, vl_q, sw_q, end_q, busy_q;

    logic [BITS-1:0] sample_inc;
    logic [BITS-1:0] epoch_inc;
    logic            wd_expired;

    assign sample_inc = sample_q + BITS'(1);
    assign epoch_inc  = epoch_cnt_q + BITS'(1);
    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    // NOTE: every signal written here gets a default first, so that no path
    // through the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        train_d     = train_q;
        valid_d     = valid_q;
        epoch_d     = epoch_q;
        sample_d    = sample_q;
        epoch_cnt_d = epoch_cnt_q;
        wd_d        = wd_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    train_d     = TRAIN;
                    valid_d     = VALID;
                    epoch_d     = EPOCH;
                    sample_d    = '0;
                    epoch_cnt_d = '0;
                    err_d       = 1'b0;
                    state_d     = S_STRT;
                end
            end
            S_STRT: begin
                if (epoch_q == '0 || (train_q == '0 && valid_q == '0)) begin
                    state_d = S_FIN;
                end else if (train_q != '0) begin
                    state_d = S_T_REQ;
                end else begin
                    state_d = S_V_REQ;
                end
            end
            // The REQ states ignore s_done. Clearing the watchdog here means it
            // always starts from zero when the following WAIT state is entered.
            S_T_REQ: begin
                wd_d    = '0;
                state_d = S_T_WAIT;
            end
            S_V_REQ: begin
                wd_d    = '0;
                state_d = S_V_WAIT;
            end
            S_T_WAIT: begin
                if (s_done) begin
                    if (sample_inc == train_q) begin
                        sample_d = '0;
                        state_d  = (valid_q == '0) ? S_STORE : S_V_REQ;
                    end else begin
                        sample_d = sample_inc;
                        state_d  = S_T_REQ;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_V_WAIT: begin
                if (s_done) begin
                    if (sample_inc == valid_q) begin
                        sample_d = '0;
                        state_d  = S_STORE;
                    end else begin
                        sample_d = sample_inc;
                        state_d  = S_V_REQ;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_STORE: begin
                epoch_cnt_d = epoch_inc;
                if (epoch_inc == epoch_q) begin
                    state_d = S_FIN;
                end else if (train_q != '0) begin
                    state_d = S_T_REQ;
                end else begin
                    state_d = S_V_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            train_q     <= '0;
            valid_q     <= '0;
            epoch_q     <= '0;
            sample_q    <= '0;
            epoch_cnt_q <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            tr_q        <= 1'b0;
            vl_q        <= 1'b0;
            sw_q        <= 1'b0;
            end_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_q     <= train_d;
            valid_q     <= valid_d;
            epoch_q     <= epoch_d;
            sample_q    <= sample_d;
            epoch_cnt_q <= epoch_cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            start_q     <= (state_d == S_STRT);
            tr_q        <= (state_d == S_T_REQ);
            vl_q        <= (state_d == S_V_REQ);
            sw_q        <= (state_d == S_STORE);
            end_q       <= (state_d == S_FIN);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign START      = start_q;
    assign TR         = tr_q;
    assign VL         = vl_q;
    assign SW         = sw_q;
    assign END        = end_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign sample_idx = sample_q;
    assign epoch_idx  = epoch_cnt_q;

endmodule

// File: tb/tb_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_train_sequencer
//
// Scoreboard bench. For each run the reference model turns TRAIN/VALID/EPOCH
// into the ordered list of strobe events the run must produce. Each event
// carries the sample_idx, epoch_idx and err values expected while it is high,
// and its latency from the event that triggers it. The driver pushes that list
// into the scoreboard and then answers TR/VL strobes with s_done after a random
// delay. The monitor pops one entry for every strobe the DUT shows and
// compares the two.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_train_sequencer;

    localparam int BITS    = 16;
    localparam int TIMEOUT = 8;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b1;
    logic            go     = 1'b0;
    logic            s_done = 1'b0;
    logic [BITS-1:0] TRAIN  = '0;
    logic [BITS-1:0] VALID  = '0;
    logic [BITS-1:0] EPOCH  = '0;
    logic            START, TR, VL, SW, END, busy, err;
    logic [BITS-1:0] sample_idx, epoch_idx;

    train_sequencer #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .TRAIN      (TRAIN),
        .VALID      (VALID),
        .EPOCH      (EPOCH),
        .s_done     (s_done),
        .START      (START),
        .TR         (TR),
        .VL         (VL),
        .SW         (SW),
        .END        (END),
        .busy       (busy),
        .err        (err),
        .sample_idx (sample_idx),
        .epoch_idx  (epoch_idx)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_START, EV_TR, EV_VL, EV_SW, EV_END} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       sidx;
        int       eidx;
        bit       err;
        int       gap;   // cycles after the triggering go / s_done / strobe
    } ev_t;

    ev_t scb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  trig_cyc = 0;
    bit  in_run   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        int       n_act;
        ev_kind_e kind;
        ev_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_quiet", {START, TR, VL, SW, END, busy, err}, 0);
            end else begin
                n_act = int'(START) + int'(TR) + int'(VL) + int'(SW) + int'(END);
                if (n_act > 1) check("one_strobe_per_cycle", n_act, 1);
                kind = START ? EV_START : TR ? EV_TR : VL ? EV_VL : SW ? EV_SW : EV_END;
                if (n_act == 1 && scb.size() == 0) begin
                    check("unexpected_strobe", int'(kind), -1);
                end else if (n_act == 1) begin
                    e = scb.pop_front();
                    check("strobe_kind", int'(kind), int'(e.kind));
                    check("sample_idx", sample_idx, e.sidx);
                    check("epoch_idx", epoch_idx, e.eidx);
                    check("err", err, e.err);
                    check("latency", cyc - trig_cyc, e.gap);
                    trig_cyc = cyc;
                    if (e.kind == EV_START) in_run = 1'b1;
                end
                check("busy", busy, in_run);
                if (n_act == 1 && e.kind == EV_END) in_run = 1'b0;
            end
        end
    end

    // ------------------------------------------------------- reference model
    // Builds the event list of one run. stall_at > 0 names the TR/VL strobe
    // (counted from 1) that never receives s_done, so the watchdog ends the run.
    task automatic build(input int t, input int v, input int e, input int stall_at,
                         output ev_t last);
        int n       = 0;
        bit stalled = 1'b0;
        scb.push_back('{EV_START, 0, 0, 1'b0, 1});
        if (e == 0 || (t == 0 && v == 0)) begin
            scb.push_back('{EV_END, 0, 0, 1'b0, 1});
        end else begin
            for (int ep = 0; ep < e && !stalled; ep++) begin
                for (int i = 0; i < t && !stalled; i++) begin
                    n++;
                    scb.push_back('{EV_TR, i, ep, 1'b0, 1});
                    if (n == stall_at) begin
                        stalled = 1'b1;
                        scb.push_back('{EV_END, i, ep, 1'b1, TIMEOUT + 1});
                    end
                end
                for (int j = 0; j < v && !stalled; j++) begin
                    n++;
                    scb.push_back('{EV_VL, j, ep, 1'b0, 1});
                    if (n == stall_at) begin
                        stalled = 1'b1;
                        scb.push_back('{EV_END, j, ep, 1'b1, TIMEOUT + 1});
                    end
                end
                if (!stalled) scb.push_back('{EV_SW, 0, ep, 1'b0, 1});
            end
            if (!stalled) scb.push_back('{EV_END, 0, e, 1'b0, 1});
        end
        last = scb[scb.size() - 1];
    endtask

    // ----------------------------------------------------------------- driver
    task automatic run(input int t, input int v, input int e, input int stall_at,
                       input bit hold_go, input bit early_done, input bit rst_mid);
        ev_t last;
        int  budget     = 3000;
        int  countdown  = -1;
        int  strobes    = 0;
        bit  finished   = 1'b0;
        bit  reset_next = 1'b0;

        build(t, v, e, stall_at, last);
        @(negedge clk);
        TRAIN    = BITS'(t);
        VALID    = BITS'(v);
        EPOCH    = BITS'(e);
        go       = 1'b1;
        trig_cyc = cyc;
        while (!finished) begin
            @(negedge clk);
            budget--;
            s_done = 1'b0;
            if (!hold_go) go = 1'b0;
            // Latched counts must not follow the inputs once the run has started.
            TRAIN = BITS'($urandom_range(0, 7));
            VALID = BITS'($urandom_range(0, 7));
            EPOCH = BITS'($urandom_range(0, 7));
            if (reset_next) begin
                #2 rst_n = 1'b0;
                #1 check("async_reset_outputs",
                         {START, TR, VL, SW, END, busy, err, sample_idx, epoch_idx}, 0);
                scb.delete();
                in_run   = 1'b0;
                finished = 1'b1;
            end else if (END) begin
                finished = 1'b1;
                go       = 1'b0;
            end else if (TR || VL) begin
                strobes++;
                if (rst_mid && strobes == t + v + 1) begin
                    reset_next = 1'b1;
                end else if (strobes == stall_at) begin
                    countdown = -1;
                end else begin
                    countdown = $urandom_range(early_done ? 2 : 1, TIMEOUT);
                end
                if (early_done) s_done = 1'b1;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    s_done    = 1'b1;
                    trig_cyc  = cyc;
                    countdown = -1;
                end
            end
            if (budget == 0 && !finished) begin
                check("run_cycle_budget", budget, 1);
                finished = 1'b1;
                go       = 1'b0;
            end
        end

        if (rst_mid) begin
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check("idx_after_reset", {sample_idx, epoch_idx}, 0);
        end else begin
            repeat (3) @(negedge clk);
            check("scoreboard_drained", scb.size(), 0);
            check("idle_busy", busy, 0);
            check("sticky_err", err, last.err);
            check("held_sample_idx", sample_idx, last.sidx);
            check("held_epoch_idx", epoch_idx, last.eidx);
        end
        scb.delete();
    endtask

    initial begin : driver
        int t, v, e, total, stall;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {START, TR, VL, SW, END, busy, err, sample_idx, epoch_idx}, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(3, 2, 2, 0, 1'b0, 1'b0, 1'b0);  // nominal two-epoch run
        run(3, 2, 0, 0, 1'b0, 1'b0, 1'b0);  // EPOCH=0: START then END
        run(2, 0, 1, 0, 1'b0, 1'b0, 1'b0);  // no validation phase
        run(3, 2, 2, 1, 1'b0, 1'b0, 1'b0);  // watchdog on first TR
        run(2, 3, 1, 0, 1'b0, 1'b0, 1'b0);  // err cleared by the next go
        run(3, 2, 2, 0, 1'b0, 1'b0, 1'b1);  // reset during epoch-1 T_WAIT
        run(3, 2, 2, 0, 1'b0, 1'b0, 1'b0);  // restart after reset
        run(3, 2, 2, 0, 1'b1, 1'b1, 1'b0);  // go held, s_done in REQ states
        run(0, 3, 2, 0, 1'b0, 1'b0, 1'b0);  // TRAIN=0
        run(0, 0, 3, 0, 1'b0, 1'b0, 1'b0);  // no samples at all
        run(2, 2, 2, 7, 1'b0, 1'b0, 1'b0);  // watchdog on a VL mid-run

        for (int r = 0; r < 16; r++) begin
            t     = $urandom_range(0, 4);
            v     = $urandom_range(0, 4);
            e     = $urandom_range(0, 3);
            total = e * (t + v);
            stall = (total > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, total) : 0;
            run(t, v, e, stall, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
